morse_symbol_sequencer: RTL and testbench

MORSE_SYMBOL_SEQUENCER -- requirements
Module: morse_symbol_sequencer

---
 rtl/morse_pkg.sv | 25 ++
 rtl/morse_sym_fifo.sv | 76 +++++++
 rtl/morse_symbol_sequencer.sv | 158 +++++++++++++++
 tb/tb_morse_symbol_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse symbol sequencer.
//   sym_code_t  : 2-bit symbol encoding presented on sym_code
//   fsm_state_t : keying FSM state encoding
//   UNIT_W      : width of the dot-unit length input
//   THRESH_W    : width needed to hold 5 * (2^UNIT_W - 1)
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_DOT      = 2'b00,
    SYM_DASH     = 2'b01,
    SYM_CHAR_END = 2'b10,
    SYM_WORD_END = 2'b11
  } sym_code_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MARK     = 2'b01,
    ST_SPACE    = 2'b10,
    ST_CHAR_GAP = 2'b11
  } fsm_state_t;

  localparam int UNIT_W   = 8;
  localparam int THRESH_W = UNIT_W + 3;

endpackage

// File: rtl/morse_sym_fifo.sv
// Synchronous symbol FIFO with count-based full/empty.
//   mid_clk, rst        : clock, synchronous active-high reset
//   push, push_code     : write request and symbol
//   pop_ready           : consumer accepts head when head_valid
//   head_valid          : FIFO not empty
//   head_code           : symbol at the head (00 when empty)
//   drop                : pulse, a push was discarded (full, no pop)
module morse_sym_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       mid_clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] push_code,
  input  logic       pop_ready,
  output logic       head_valid,
  output logic [1:0] head_code,
  output logic       drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [1:0]       mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic [DEPTH-1:0] slot_we;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);
  assign pop   = ~empty & pop_ready;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = wr_en && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge mid_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_we[i]) mem_reg[i] <= push_code;
    end
  end

  always_ff @(posedge mid_clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_valid = ~empty;
  // Storage is not reset, so mask the head while empty.
  assign head_code  = empty ? 2'b00 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Turns a raw Morse key into a queue of dot/dash/char_end/word_end symbols.
//   mid_clk, rst   : clock, synchronous active-high reset
//   key_in         : raw asynchronous key (1 = pressed)
//   enable         : 0 freezes FSM and duration counter
//   unit_len       : dot unit in cycles (0 treated as 1)
//   sym_valid/sym_ready/sym_code : symbol queue head handshake
//   overflow       : sticky, a symbol was dropped on a full queue
//   busy           : FSM not in IDLE
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int DEB_CYC    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 12
) (
  input  logic              mid_clk,
  input  logic              rst,
  input  logic              key_in,
  input  logic              enable,
  input  logic [UNIT_W-1:0] unit_len,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [1:0]        sym_code,
  output logic              overflow,
  output logic              busy
);

  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam int CMP_W = (CNT_W > THRESH_W) ? CNT_W : THRESH_W;

  logic             sync1_reg, sync2_reg;
  logic             key_db_reg, key_last_reg;
  logic [DEB_W-1:0] deb_cnt_reg;
  logic [CNT_W-1:0] cnt_reg;
  fsm_state_t       state_reg, state_next;
  logic             overflow_reg;
  logic             key_rise, key_fall;
  logic             push;
  logic [1:0]       push_code;
  logic             drop;

  // Synchronizer and debouncer: key_db follows only after DEB_CYC
  // consecutive synchronized samples disagree with it.
  always_ff @(posedge mid_clk) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      key_db_reg  <= 1'b0;
      deb_cnt_reg <= '0;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
      if (sync2_reg == key_db_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        key_db_reg  <= sync2_reg;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
      end
    end
  end

  // Edge reference only advances while enabled, so an edge that happens
  // during a freeze is still seen once enable returns.
  assign key_rise = key_db_reg & ~key_last_reg;
  assign key_fall = ~key_db_reg & key_last_reg;

  always_ff @(posedge mid_clk) begin
    if (rst) begin
      key_last_reg <= 1'b0;
      cnt_reg      <= '0;
    end else if (enable) begin
      key_last_reg <= key_db_reg;
      if (key_rise || key_fall)  cnt_reg <= '0;
      else if (cnt_reg != '1)    cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Thresholds are recomputed every cycle from the live unit_len.
  logic [THRESH_W-1:0] unit_eff, t2, t5;
  logic [CMP_W-1:0]    cnt_ext, t2_ext, t5_ext;

  assign unit_eff = (unit_len == '0) ? THRESH_W'(1) : THRESH_W'(unit_len);
  assign t2       = unit_eff << 1;
  assign t5       = (unit_eff << 2) + unit_eff;
  assign cnt_ext  = CMP_W'(cnt_reg);
  assign t2_ext   = CMP_W'(t2);
  assign t5_ext   = CMP_W'(t5);

  always_ff @(posedge mid_clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Each gap threshold fires on the state exit, hence once per gap.
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    push_code  = SYM_DOT;
    if (enable) begin
      case (state_reg)
        ST_IDLE: begin
          if (key_rise) state_next = ST_MARK;
        end
        ST_MARK: begin
          if (key_fall) begin
            push       = 1'b1;
            push_code  = (cnt_ext < t2_ext) ? SYM_DOT : SYM_DASH;
            state_next = ST_SPACE;
          end
        end
        ST_SPACE: begin
          if (key_rise) begin
            state_next = ST_MARK;
          end else if (cnt_ext >= t2_ext) begin
            push       = 1'b1;
            push_code  = SYM_CHAR_END;
            state_next = ST_CHAR_GAP;
          end
        end
        ST_CHAR_GAP: begin
          if (key_rise) begin
            state_next = ST_MARK;
          end else if (cnt_ext >= t5_ext) begin
            push       = 1'b1;
            push_code  = SYM_WORD_END;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  morse_sym_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .mid_clk   (mid_clk),
    .rst       (rst),
    .push      (push),
    .push_code (push_code),
    .pop_ready (sym_ready),
    .head_valid(sym_valid),
    .head_code (sym_code),
    .drop      (drop)
  );

  always_ff @(posedge mid_clk) begin
    if (rst)       overflow_reg <= 1'b0;
    else if (drop) overflow_reg <= 1'b1;
  end

  assign overflow = overflow_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
module tb_morse_symbol_sequencer;
  import morse_pkg::*;

  logic       mid_clk = 1'b0;
  logic       rst, key_in, enable, sym_ready;
  logic [7:0] unit_len;
  logic       sym_valid, overflow, busy;
  logic [1:0] sym_code;
  logic       f_valid, f_overflow, f_busy;
  logic [1:0] f_code;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [1:0] got_q[$];
  int         got_t[$];
  logic [1:0] f_q[$];
  int         f_t[$];

  morse_symbol_sequencer dut (
    .mid_clk(mid_clk), .rst(rst), .key_in(key_in), .enable(enable),
    .unit_len(unit_len), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_code(sym_code), .overflow(overflow), .busy(busy)
  );

  // Second instance without debounce delay, for single-cycle key presses.
  morse_symbol_sequencer #(.DEB_CYC(1)) dut_fast (
    .mid_clk(mid_clk), .rst(rst), .key_in(key_in), .enable(enable),
    .unit_len(unit_len), .sym_valid(f_valid), .sym_ready(sym_ready),
    .sym_code(f_code), .overflow(f_overflow), .busy(f_busy)
  );

  always #5 mid_clk = ~mid_clk;
  always @(posedge mid_clk) cyc <= cyc + 1;

  always @(negedge mid_clk) begin
    if (!rst && sym_valid && sym_ready) begin
      got_q.push_back(sym_code);
      got_t.push_back(cyc);
      $display("sym main code=%0d cyc=%0d", sym_code, cyc);
    end
    if (!rst && f_valid && sym_ready) begin
      f_q.push_back(f_code);
      f_t.push_back(cyc);
      $display("sym fast code=%0d cyc=%0d", f_code, cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge mid_clk);
    #1;
  endtask

  task automatic press(input int hi, input int lo);
    key_in = 1'b1;
    tick(hi);
    key_in = 1'b0;
    tick(lo);
  endtask

  task automatic clear_log();
    got_q.delete(); got_t.delete();
    f_q.delete();   f_t.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = 1'b0; enable = 1'b1; sym_ready = 1'b1; unit_len = 8'd4;
    tick(3);
    total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", sym_valid); end
    total++; if (sym_code !== 2'b00) begin bad++; $display("FAIL reset_code got=%b want=00", sym_code); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_dot();
    logic [1:0] exp_q[$];
    logic [1:0] g;
    clear_log();
    unit_len = 8'd4;
    exp_q = '{SYM_DOT, SYM_CHAR_END, SYM_WORD_END};
    press(4, 60);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL dot_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 2'bxx;
      total++; if (g !== exp_q[i]) begin bad++; $display("FAIL dot_sym%0d got=%b want=%b", i, g, exp_q[i]); end
    end
    if (got_t.size() == 3) begin
      total++; if (got_t[1] - got_t[0] != 9) begin bad++; $display("FAIL dot_gap_t2 got=%0d want=9", got_t[1] - got_t[0]); end
      total++; if (got_t[2] - got_t[1] != 12) begin bad++; $display("FAIL dot_gap_t5 got=%0d want=12", got_t[2] - got_t[1]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dot_busy got=%b want=0", busy); end
  endtask

  task automatic test_dash_dot();
    logic [1:0] exp_q[$];
    logic [1:0] g;
    clear_log();
    unit_len = 8'd4;
    exp_q = '{SYM_DASH, SYM_DOT, SYM_CHAR_END, SYM_WORD_END};
    press(12, 3);
    press(4, 60);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL dashdot_count got=%0d want=4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 2'bxx;
      total++; if (g !== exp_q[i]) begin bad++; $display("FAIL dashdot_sym%0d got=%b want=%b", i, g, exp_q[i]); end
    end
    if (got_t.size() == 4) begin
      total++; if (got_t[1] - got_t[0] != 7) begin bad++; $display("FAIL dashdot_spacing got=%0d want=7", got_t[1] - got_t[0]); end
      total++; if (got_t[2] - got_t[1] != 9) begin bad++; $display("FAIL dashdot_char_gap got=%0d want=9", got_t[2] - got_t[1]); end
    end
  endtask

  task automatic test_glitch();
    logic seen_busy;
    clear_log();
    seen_busy = 1'b0;
    key_in = 1'b1;
    tick(1);
    key_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy) seen_busy = 1'b1;
    end
    total++; if (seen_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", seen_busy); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL glitch_count got=%0d want=0", got_q.size()); end
  endtask

  task automatic test_unit_zero();
    logic [1:0] exp_q[$];
    logic [1:0] g;
    clear_log();
    unit_len = 8'd0;
    exp_q = '{SYM_DOT, SYM_CHAR_END, SYM_WORD_END};
    press(1, 30);
    total++; if (f_q.size() != 3) begin bad++; $display("FAIL u0_count got=%0d want=3", f_q.size()); end
    for (int i = 0; i < 3; i++) begin
      g = (i < f_q.size()) ? f_q[i] : 2'bxx;
      total++; if (g !== exp_q[i]) begin bad++; $display("FAIL u0_sym%0d got=%b want=%b", i, g, exp_q[i]); end
    end
    if (f_t.size() == 3) begin
      total++; if (f_t[1] - f_t[0] != 3) begin bad++; $display("FAIL u0_char_gap got=%0d want=3", f_t[1] - f_t[0]); end
      total++; if (f_t[2] - f_t[1] != 3) begin bad++; $display("FAIL u0_word_gap got=%0d want=3", f_t[2] - f_t[1]); end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL u0_main_filtered got=%0d want=0", got_q.size()); end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_q[$];
    logic [1:0] g;
    clear_log();
    unit_len = 8'd4;
    sym_ready = 1'b0;
    exp_q = '{SYM_DASH, SYM_DOT, SYM_DASH, SYM_DOT};
    press(12, 3);
    press(4, 3);
    press(12, 3);
    press(4, 3);
    press(12, 60);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    total++; if (sym_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b want=1", sym_valid); end
    total++; if (sym_code !== SYM_DASH) begin bad++; $display("FAIL ovf_head got=%b want=01", sym_code); end
    tick(5);
    total++; if (sym_code !== SYM_DASH) begin bad++; $display("FAIL ovf_hold got=%b want=01", sym_code); end
    sym_ready = 1'b1;
    tick(10);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL ovf_count got=%0d want=4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 2'bxx;
      total++; if (g !== exp_q[i]) begin bad++; $display("FAIL ovf_sym%0d got=%b want=%b", i, g, exp_q[i]); end
    end
    total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", sym_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_enable_hold();
    logic [1:0] exp_q[$];
    logic [1:0] g;
    int n;
    clear_log();
    unit_len = 8'd10;
    exp_q = '{SYM_DOT, SYM_CHAR_END, SYM_WORD_END};
    press(3, 0);
    n = 0;
    while (got_q.size() == 0 && n < 30) begin
      tick(1);
      n++;
    end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL en_dot_seen got=%0d want=1", got_q.size()); end
    enable = 1'b0;
    tick(60);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL en_frozen_count got=%0d want=1", got_q.size()); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL en_frozen_busy got=%b want=1", busy); end
    enable = 1'b1;
    tick(80);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL en_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 2'bxx;
      total++; if (g !== exp_q[i]) begin bad++; $display("FAIL en_sym%0d got=%b want=%b", i, g, exp_q[i]); end
    end
    if (got_t.size() == 3) begin
      total++; if (got_t[1] - got_t[0] != 81) begin bad++; $display("FAIL en_char_gap got=%0d want=81", got_t[1] - got_t[0]); end
    end
  endtask

  task automatic test_reset_mid_mark();
    int n;
    clear_log();
    unit_len = 8'd4;
    key_in = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      tick(1);
      n++;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmm_mark got=%b want=1", busy); end
    tick(2);
    rst = 1'b1;
    key_in = 1'b0;
    tick(1);
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmm_busy got=%b want=0", busy); end
    total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL rmm_valid got=%b want=0", sym_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmm_overflow got=%b want=0", overflow); end
    tick(40);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rmm_no_symbol got=%0d want=0", got_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmm_idle got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_dot();
    test_dash_dot();
    test_glitch();
    test_unit_zero();
    test_overflow();
    test_enable_hold();
    test_reset_mid_mark();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
